// File: rtl/serum_arb_pkg.sv
// serum_arb_pkg
// Shared types and helpers for the serum packet arbiter.
//   arb_state_e : arbiter FSM states (idle / packet granted)
//   STAT_W      : width of the per-requester packet counters
//   rr_next     : round-robin successor of an index, wrapping n-1 -> 0
package serum_arb_pkg;

  typedef enum logic {ARB_IDLE, ARB_GRANT} arb_state_e;

  localparam int STAT_W = 16;

  function automatic int unsigned rr_next(input int unsigned ptr, input int unsigned n);
    return (ptr + 1 >= n) ? 0 : ptr + 1;
  endfunction

endpackage

// File: rtl/serum_pkt_arb_if.sv
// serum_pkt_arb_if
// Bundles the upstream per-requester beat channels and the shared downstream
// beat channel of the packet arbiter.
//   req_valid/req_data/req_last : per-requester beats, requester i at [i*DW +: DW]
//   req_ready                   : per-requester ready, only the owner may see 1
//   out_valid/out_data/out_last : downstream beat
//   out_ready                   : downstream ready
// Modports: master = traffic side (sources + sink), slave = arbiter.
interface serum_pkt_arb_if #(
  parameter int N_REQ = 4,
  parameter int DW    = 32
);

  logic [N_REQ-1:0]    req_valid;
  logic [N_REQ*DW-1:0] req_data;
  logic [N_REQ-1:0]    req_last;
  logic [N_REQ-1:0]    req_ready;
  logic                out_valid;
  logic [DW-1:0]       out_data;
  logic                out_last;
  logic                out_ready;

  modport master (
    output req_valid, req_data, req_last, out_ready,
    input  req_ready, out_valid, out_data, out_last
  );

  modport slave (
    input  req_valid, req_data, req_last, out_ready,
    output req_ready, out_valid, out_data, out_last
  );

endinterface

// File: rtl/serum_rr_pick.sv
// serum_rr_pick
// Combinational round-robin picker: finds the first set bit of req searching
// upward from ptr and wrapping at N_REQ-1.
//   req   : request vector
//   ptr   : search start index
//   found : at least one request set
//   idx   : index of the selected request (0 when none)
module serum_rr_pick #(
  parameter int N_REQ = 4,
  localparam int IW   = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IW-1:0]    ptr,
  output logic             found,
  output logic [IW-1:0]    idx
);

  localparam int SW = IW + 1;

  logic [N_REQ-1:0] rot;
  logic [SW-1:0]    sum;

  // Rotate so the search start lands on bit 0, then take the lowest set bit
  // (descending loop: the last hit written is the lowest one) and map the
  // rotated position back to a requester index modulo N_REQ.
  always_comb begin
    rot   = (req >> ptr) | (req << (N_REQ - int'(ptr)));
    found = 1'b0;
    idx   = '0;
    sum   = '0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      if (rot[i]) begin
        found = 1'b1;
        sum   = {1'b0, ptr} + SW'(i);
        if (sum >= SW'(N_REQ)) sum = sum - SW'(N_REQ);
        idx   = sum[IW-1:0];
      end
    end
  end

endmodule

// File: rtl/serum_pkt_arb.sv
// serum_pkt_arb
// Round-robin packet arbiter: one downstream packet port shared by N_REQ
// sources. A whole packet (up to and including last) is passed through with
// zero latency, then the arbiter spends one idle cycle re-arbitrating.
// A watchdog forces last on beat MAX_BEATS of a packet and pulses wdog_err.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : serum_pkt_arb_if.slave, upstream and downstream beat channels
//   grant_id   : current / most recent owner
//   busy       : packet in progress
//   wdog_err   : one-cycle pulse after a watchdog-forced release
//   stat_sel   : packet counter readout select
//   stat_cnt   : registered packet count of requester stat_sel
// Build option: SERUM_ARB_STATS_EN adds 16-bit saturating per-requester
// packet counters; when undefined stat_cnt is 0 and stat_sel is ignored.
module serum_pkt_arb
  import serum_arb_pkg::*;
#(
  parameter int N_REQ     = 4,
  parameter int DW        = 32,
  parameter int MAX_BEATS = 64,
  localparam int IW       = $clog2(N_REQ)
) (
  input  logic              clk,
  input  logic              rst_n,
  serum_pkt_arb_if.slave    bus,
  output logic [IW-1:0]     grant_id,
  output logic              busy,
  output logic              wdog_err,
  input  logic [IW-1:0]     stat_sel,
  output logic [STAT_W-1:0] stat_cnt
);

  localparam int BW = $clog2(MAX_BEATS);

  arb_state_e       state_q, state_d;
  logic [IW-1:0]    ptr_q, ptr_d;
  logic [IW-1:0]    grant_q, grant_d;
  logic [BW-1:0]    beat_cnt_q, beat_cnt_d;
  logic             wdog_q, wdog_d;

  logic             pick_found;
  logic [IW-1:0]    pick_idx;
  logic             sel_valid, sel_last, out_valid_c, out_last_c;
  logic             force_last, accept, release_pkt;
  logic [DW-1:0]    sel_data;
  logic [N_REQ-1:0] req_ready_c;

  serum_rr_pick #(.N_REQ(N_REQ)) u_pick (
    .req   (bus.req_valid),
    .ptr   (ptr_q),
    .found (pick_found),
    .idx   (pick_idx)
  );

  // Owner mux: the granted source drives the downstream port directly and
  // only it sees out_ready; nothing is buffered.
  always_comb begin
    sel_valid   = 1'b0;
    sel_last    = 1'b0;
    sel_data    = '0;
    req_ready_c = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (grant_q == IW'(i)) begin
        sel_valid      = bus.req_valid[i];
        sel_last       = bus.req_last[i];
        sel_data       = bus.req_data[i*DW +: DW];
        req_ready_c[i] = (state_q == ARB_GRANT) && bus.out_ready;
      end
    end
  end

  assign force_last  = (state_q == ARB_GRANT) && (beat_cnt_q == BW'(MAX_BEATS - 1));
  assign out_valid_c = (state_q == ARB_GRANT) && sel_valid;
  assign out_last_c  = sel_last || force_last;
  assign accept      = out_valid_c && bus.out_ready;
  assign release_pkt = accept && out_last_c;

  assign bus.out_valid = out_valid_c;
  assign bus.out_data  = sel_data;
  assign bus.out_last  = out_last_c;
  assign bus.req_ready = req_ready_c;

  // Next-state logic: IDLE picks an owner, GRANT counts beats until a real or
  // forced last is accepted, then hands the pointer to the next requester.
  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    grant_d    = grant_q;
    beat_cnt_d = beat_cnt_q;
    wdog_d     = 1'b0;
    case (state_q)
      ARB_IDLE: begin
        if (pick_found) begin
          grant_d = pick_idx;
          state_d = ARB_GRANT;
        end
      end
      ARB_GRANT: begin
        if (release_pkt) begin
          state_d    = ARB_IDLE;
          ptr_d      = IW'(rr_next(32'(grant_q), 32'(N_REQ)));
          beat_cnt_d = '0;
          wdog_d     = force_last;
        end else if (accept) begin
          beat_cnt_d = beat_cnt_q + 1'b1;
        end
      end
      default: state_d = ARB_IDLE;
    endcase
  end

  // State registers; reset truncates any packet in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ARB_IDLE;
      ptr_q      <= '0;
      grant_q    <= '0;
      beat_cnt_q <= '0;
      wdog_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      grant_q    <= grant_d;
      beat_cnt_q <= beat_cnt_d;
      wdog_q     <= wdog_d;
    end
  end

  assign grant_id = grant_q;
  assign busy     = (state_q == ARB_GRANT);
  assign wdog_err = wdog_q;

`ifdef SERUM_ARB_STATS_EN
  logic [STAT_W-1:0] cnt_q [N_REQ];
  logic [STAT_W-1:0] cnt_d [N_REQ];
  logic [STAT_W-1:0] stat_q, stat_d;

  // Saturating count of released packets per owner (forced releases too);
  // readout is registered, so it shows the count as of the previous cycle.
  always_comb begin
    stat_d = '0;
    for (int i = 0; i < N_REQ; i++) begin
      cnt_d[i] = cnt_q[i];
      if (release_pkt && (grant_q == IW'(i)) && (cnt_q[i] != '1)) cnt_d[i] = cnt_q[i] + 1'b1;
      if (stat_sel == IW'(i)) stat_d = cnt_q[i];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < N_REQ; i++) cnt_q[i] <= '0;
      stat_q <= '0;
    end else begin
      for (int i = 0; i < N_REQ; i++) cnt_q[i] <= cnt_d[i];
      stat_q <= stat_d;
    end
  end

  assign stat_cnt = stat_q;
`else
  logic unused_stat_sel;
  assign unused_stat_sel = ^stat_sel;
  assign stat_cnt        = '0;
`endif

endmodule

// File: tb/tb_serum_pkt_arb.sv
// tb_serum_pkt_arb
// Randomized bench for serum_pkt_arb. A driver feeds per-source beat queues,
// a packet-level reference model predicts owner order and beat stream, and a
// monitor compares every cycle. Build with or without SERUM_ARB_STATS_EN.
module tb_serum_pkt_arb;

  localparam int N    = 4;
  localparam int DW   = 32;
  localparam int MAXB = 64;

  typedef struct packed {logic [DW-1:0] d; logic l;} beat_t;
  typedef struct packed {logic [1:0] id; logic [DW-1:0] d; logic l; logic f;} exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [1:0]  grant_id, stat_sel;
  logic        busy, wdog_err;
  logic [15:0] stat_cnt;

  always #5 clk = ~clk;

  serum_pkt_arb_if #(.N_REQ(N), .DW(DW)) bus ();

  serum_pkt_arb #(.N_REQ(N), .DW(DW), .MAX_BEATS(MAXB)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .bus      (bus),
    .grant_id (grant_id),
    .busy     (busy),
    .wdog_err (wdog_err),
    .stat_sel (stat_sel),
    .stat_cnt (stat_cnt)
  );

  beat_t       src_q [N][$];
  exp_t        exp_q [$];
  int          grant_log [$];
  int          n_checks = 0, n_fail = 0;
  int          valid_pct = 100, ready_pct = 100;
  bit          ready_low = 0, stat_rand = 0;
  logic [N-1:0] acc = '0;
  int          seq = 0;
  logic [DW-1:0] pkt_first;

  bit          mbusy = 0, first_cyc = 0, wdog_exp = 0;
  int          mptr = 0, mowner = 0, mlast_owner = 0, wdog_seen = 0;
  int          cnt_m [N];
  logic [15:0] stat_saved = '0;

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] want);
    n_checks++;
    if (act !== want) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, want);
    end
  endtask

  // Queue one whole packet of n beats on source s; data tags the source.
  task automatic applyStimulus(input int s, input int n);
    beat_t b;
    pkt_first = {8'(s), 24'(seq)};
    for (int j = 0; j < n; j++) begin
      b.d = {8'(s), 24'(seq)};
      b.l = (j == n - 1);
      seq++;
      src_q[s].push_back(b);
    end
  endtask

  function automatic bit allEmpty();
    for (int i = 0; i < N; i++) if (src_q[i].size() != 0) return 0;
    return 1;
  endfunction

  task automatic waitDrain(input string name, input int budget);
    bit done = 0;
    for (int c = 0; c < budget && !done; c++) begin
      @(negedge clk); #1;
      if (stat_rand) stat_sel = 2'($urandom_range(3));
      #3;
      done = allEmpty() && !mbusy && (exp_q.size() == 0);
    end
    checkOutput(name, 64'(done), 1);
  endtask

  task automatic waitGrant(input string name, input int id, input int budget);
    bit hit = 0;
    for (int c = 0; c < budget && !hit; c++) begin
      @(negedge clk); #4;
      hit = busy && (grant_id == 2'(id));
    end
    checkOutput(name, 64'(hit), 1);
  endtask

  task automatic doReset();
    @(negedge clk); #1;
    rst_n = 1'b0;
    for (int i = 0; i < N; i++) src_q[i].delete();
    repeat (2) @(negedge clk);
    #1 rst_n = 1'b1;
  endtask

  // Driver: retire beats accepted last cycle, present the next beat of each
  // source with random valid gaps, and randomize downstream ready.
  initial begin
    bus.req_valid = '0;
    bus.req_data  = '0;
    bus.req_last  = '0;
    bus.out_ready = 1'b0;
    forever begin
      @(negedge clk);
      for (int i = 0; i < N; i++)
        if (acc[i] && src_q[i].size() > 0) void'(src_q[i].pop_front());
      for (int i = 0; i < N; i++) begin
        if (src_q[i].size() > 0 && $urandom_range(99) < valid_pct) begin
          bus.req_valid[i]          = 1'b1;
          bus.req_data[i*DW +: DW]  = src_q[i][0].d;
          bus.req_last[i]           = src_q[i][0].l;
        end else begin
          bus.req_valid[i]          = 1'b0;
          bus.req_data[i*DW +: DW]  = $urandom;
          bus.req_last[i]           = 1'($urandom_range(1));
        end
      end
      bus.out_ready = !ready_low && ($urandom_range(99) < ready_pct);
      #3;
      acc = bus.req_valid & bus.req_ready;
    end
  end

  // Monitor + reference model: at arbitration the owner is the first
  // requesting source at or after the model pointer; the packet is the
  // owner's queued beats up to its last, cut at MAXB beats with forced last.
  initial begin
    int   s, taken;
    bit   found;
    exp_t e;
    logic [N-1:0] rr_exp;
    forever begin
      @(negedge clk); #3;
      if (!rst_n) begin
        exp_q.delete();
        mbusy = 0; first_cyc = 0; wdog_exp = 0;
        mptr = 0; mlast_owner = 0; stat_saved = '0;
        for (int i = 0; i < N; i++) cnt_m[i] = 0;
      end else begin
        if (wdog_err) wdog_seen++;
        checkOutput("wdog_err", 64'(wdog_err), 64'(wdog_exp));
        wdog_exp = 0;
`ifdef SERUM_ARB_STATS_EN
        checkOutput("stat_cnt", 64'(stat_cnt), 64'(stat_saved));
`else
        checkOutput("stat_cnt", 64'(stat_cnt), 0);
`endif
        stat_saved = 16'(cnt_m[stat_sel]);
        if (!mbusy) begin
          checkOutput("idle_busy", 64'(busy), 0);
          checkOutput("idle_out_valid", 64'(bus.out_valid), 0);
          checkOutput("idle_req_ready", 64'(bus.req_ready), 0);
          checkOutput("idle_grant_id", 64'(grant_id), 64'(mlast_owner));
          if (bus.req_valid != '0) begin
            found = 0;
            for (int k = 0; k < N; k++) begin
              s = (mptr + k) % N;
              if (!found && bus.req_valid[s]) begin
                found  = 1;
                mowner = s;
              end
            end
            taken = 0;
            for (int j = 0; j < src_q[mowner].size(); j++) begin
              taken++;
              e.id = 2'(mowner);
              e.d  = src_q[mowner][j].d;
              e.f  = (taken == MAXB);
              e.l  = src_q[mowner][j].l || e.f;
              exp_q.push_back(e);
              if (e.l) break;
            end
            mbusy = 1; first_cyc = 1; mlast_owner = mowner;
          end
        end else begin
          if (first_cyc) begin
            grant_log.push_back(int'(grant_id));
            first_cyc = 0;
          end
          rr_exp = bus.out_ready ? (4'b0001 << mowner) : 4'b0000;
          checkOutput("grant_busy", 64'(busy), 1);
          checkOutput("grant_id", 64'(grant_id), 64'(mowner));
          checkOutput("out_valid", 64'(bus.out_valid), 64'(bus.req_valid[mowner]));
          checkOutput("req_ready", 64'(bus.req_ready), 64'(rr_exp));
          if (bus.out_valid) begin
            checkOutput("beat_expected", 64'(exp_q.size() > 0), 1);
            if (exp_q.size() > 0) begin
              checkOutput("out_data", 64'(bus.out_data), 64'(exp_q[0].d));
              checkOutput("out_last", 64'(bus.out_last), 64'(exp_q[0].l));
              if (bus.out_ready) begin
                e = exp_q.pop_front();
                if (e.l) begin
                  mbusy = 0;
                  mptr  = (mowner + 1) % N;
                  if (cnt_m[mowner] < 65535) cnt_m[mowner]++;
                  if (e.f) wdog_exp = 1;
                end
              end
            end
          end
        end
      end
    end
  end

  initial begin
    int ws;
    logic [DW-1:0] held;
    stat_sel = 2'd0;
    repeat (3) @(negedge clk);
    #1 rst_n = 1'b1;

    // Idle after reset: nothing requested.
    repeat (10) begin
      @(negedge clk); #4;
      checkOutput("rst_out_valid", 64'(bus.out_valid), 0);
      checkOutput("rst_busy", 64'(busy), 0);
      checkOutput("rst_grant_id", 64'(grant_id), 0);
      checkOutput("rst_req_ready", 64'(bus.req_ready), 0);
    end

    // Fairness: all sources back-to-back 3-beat packets.
    grant_log.delete();
    @(negedge clk); #1;
    for (int p = 0; p < 3; p++) for (int s = 0; s < N; s++) applyStimulus(s, 3);
    waitDrain("fair_drain", 200);
    for (int k = 0; k < 5; k++)
      checkOutput($sformatf("fair_order%0d", k), 64'(grant_log.size() > k ? grant_log[k] : -1), 64'(k % N));

    // Downstream stall mid-packet of source 2.
    @(negedge clk); #1;
    applyStimulus(2, 8);
    waitGrant("stall_grant", 2, 20);
    ready_low = 1;
    held = pkt_first + 1;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk); #4;
      checkOutput("stall_data", 64'(bus.out_data), 64'(held));
      checkOutput("stall_grant_id", 64'(grant_id), 2);
      checkOutput("stall_req_ready", 64'(bus.req_ready), 0);
    end
    ready_low = 0;
    waitDrain("stall_drain", 50);

    // Watchdog: 70-beat packet splits into 64 (forced last) + 6.
    ws = wdog_seen;
    grant_log.delete();
    @(negedge clk); #1;
    applyStimulus(1, 70);
    waitDrain("wdog_drain", 300);
    checkOutput("wdog_pulses", 64'(wdog_seen - ws), 1);
    checkOutput("wdog_grants", 64'(grant_log.size()), 2);

    // Random traffic with valid gaps and ready back-pressure.
    valid_pct = 70; ready_pct = 70; stat_rand = 1;
    @(negedge clk); #1;
    for (int p = 0; p < 40; p++) applyStimulus(int'($urandom_range(N - 1)), int'($urandom_range(8, 1)));
    waitDrain("rand_drain", 3000);
    stat_rand = 0;

    // Reset during beat 2 of a 4-beat packet.
    valid_pct = 100; ready_pct = 100;
    @(negedge clk); #1;
    applyStimulus(1, 4);
    waitGrant("rstmid_grant", 1, 20);
    @(negedge clk);
    @(negedge clk); #1;
    rst_n = 1'b0;
    #1;
    checkOutput("rstmid_out_valid", 64'(bus.out_valid), 0);
    checkOutput("rstmid_busy", 64'(busy), 0);
    checkOutput("rstmid_grant_id", 64'(grant_id), 0);
    checkOutput("rstmid_req_ready", 64'(bus.req_ready), 0);
    checkOutput("rstmid_wdog", 64'(wdog_err), 0);
    for (int i = 0; i < N; i++) src_q[i].delete();
    repeat (2) @(negedge clk);
    #1 rst_n = 1'b1;
    grant_log.delete();
    applyStimulus(3, 2);
    applyStimulus(0, 2);
    waitDrain("rstmid_drain", 50);
    checkOutput("rstmid_first", 64'(grant_log.size() > 0 ? grant_log[0] : -1), 0);
    checkOutput("rstmid_second", 64'(grant_log.size() > 1 ? grant_log[1] : -1), 3);

    // Packet counters: 5 packets from source 0, 2 from source 3.
    doReset();
    valid_pct = 80; ready_pct = 80;
    for (int p = 0; p < 5; p++) applyStimulus(0, 2);
    for (int p = 0; p < 2; p++) applyStimulus(3, 3);
    waitDrain("stats_drain", 200);
    @(negedge clk); #1 stat_sel = 2'd0;
    @(negedge clk); #4;
`ifdef SERUM_ARB_STATS_EN
    checkOutput("stats_sel0", 64'(stat_cnt), 5);
`else
    checkOutput("stats_sel0", 64'(stat_cnt), 0);
`endif
    #2 stat_sel = 2'd3;
    @(negedge clk); #4;
`ifdef SERUM_ARB_STATS_EN
    checkOutput("stats_sel3", 64'(stat_cnt), 2);
`else
    checkOutput("stats_sel3", 64'(stat_cnt), 0);
`endif

    repeat (3) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
